pipe_hazard_unit: RTL
=====================

// Module: pipe_hazard_unit
// PURPOSE
//  Central hazard/forwarding controller for the in-order RV64 pipeline (IF/ID/EX/LS/WB).
//  Selects forwarded rs1/rs2 operands for the EX inputs from N_FWD older stages.
//  Detects load-use and multicycle-EX hazards, and sequences multi-cycle flushes on redirect.
//  Drives the stall/flush inputs of every pipeline register. Replaces the ad-hoc forwarding stub.
// PARAMETERS
//  XLEN        64  datapath width
//  RIDX_W      5   register index width (x0 hard-wired zero)
//  N_FWD       3   forwarding sources; index 0 = youngest (EX out), N_FWD-1 = oldest (WB)
//  FLUSH_CYC   1   cycles of ID/EX squash after redirect (2 when IF memory is synchronous)
// PORTS
//  clk             in   1              clock
//  rst             in   1              synchronous, active-high reset
//  rs1_idx_i       in   RIDX_W         rs1 of instruction in ID
//  rs2_idx_i       in   RIDX_W         rs2 of instruction in ID
//  rs1_rf_i        in   XLEN           regfile read data rs1
//  rs2_rf_i        in   XLEN           regfile read data rs2
//  fw_rd_i         in   N_FWD*RIDX_W   rd of each source, packed, src k at [k*RIDX_W+:RIDX_W]
//  fw_wen_i        in   N_FWD          source k will write rd
//  fw_ready_i      in   N_FWD          source k data valid this cycle (0 = load in flight)
//  fw_data_i       in   N_FWD*XLEN     source k result, packed
//  mc_busy_i       in   1              EX multicycle op (mul/div) not done
//  jump_i          in   1              EX resolved redirect (taken branch/jal/jalr)
//  rs1_o / rs2_o   out  XLEN           resolved operand to EX register
//  stall_if_o      out  1              hold PC and IF/ID register
//  stall_id_o      out  1              hold ID/EX register
//  bubble_ex_o     out  1              load NOP into ID/EX register
//  bubble_ls_o     out  1              load NOP into EX/LS register
//  flush_id_o      out  1              clear IF/ID register
// BEHAVIOUR
//  Forwarding (combinational, 0 cycles): for rsN, pick lowest k with fw_wen_i[k] && fw_rd[k]==rsN.
//   - rsN==0 -> zero, never forwarded. No match -> rsN_rf_i.
//  Load-use: a winning match with fw_ready_i[k]==0 is a hazard.
//   - Asserts stall_if_o, stall_id_o, bubble_ex_o. rsN_o is don't-care that cycle.
//  State machine (state reg + flush counter cnt, width clog2(FLUSH_CYC+1)):
//   - RUN:
//     - mc_busy_i -> MC (same cycle: stall_if/stall_id=1, bubble_ls=1).
//     - else jump_i -> FLUSH with cnt=FLUSH_CYC-1 (same cycle: flush_id=1, bubble_ex=1).
//     - else load-use handled combinationally; stay in RUN.
//   - MC: outputs as above while mc_busy_i=1. On mc_busy_i=0 -> RUN; jump_i is not sampled in that cycle.
//   - FLUSH: flush_id=1, bubble_ex=1.
//     - cnt==0 -> RUN, else cnt-1. jump_i ignored (younger, squashed).
//     - Load-use stall suppressed (its consumer is being squashed).
//  Priority, same cycle: mc_busy_i > jump_i > load-use. jump_i while mc_busy_i=1 is ignored.
//   - EX holds the op, so the redirect re-presents when busy drops.
//  Reset (sync, rst=1): state=RUN, cnt=0. While rst=1: flush_id_o=1, bubble_ex_o=1, bubble_ls_o=1, stalls=0.
//   - Reset mid-FLUSH or mid-MC aborts to RUN on the next edge.
//  FLUSH_CYC=1: FLUSH lasts exactly one cycle after the jump cycle (2 squashed slots total).
// CONFIGURATION
//  HAZARD_PERF_EN defined: 32-bit saturating counters are added (all reset to 0, all readable on outputs):
//   - perf_lu_cnt_o: load-use stall cycles
//   - perf_mc_cnt_o: multicycle stall cycles
//   - perf_flush_cnt_o: redirects accepted
//  HAZARD_PERF_EN undefined: counters and their ports are absent; no other behaviour changes.
// STRUCTURE
//  hazard_pkg (shared header):
//   - state encoding (HZ_RUN, HZ_MC, HZ_FLUSH)
//   - NOP instruction constant
//   - RIDX_W default
//  Sub-module fwd_sel: one priority match+mux per operand.
//   - Ports idx, rf data, fw buses; outputs data and hazard. Instantiated twice.
//  FSM, counter, perf counters inline in pipe_hazard_unit.
// TESTING
//  1. fw_rd={x5,x5,x5}, wen=3'b111, ready=all, data={30,20,10}, rs1=5 -> rs1_o=10 (youngest wins), no stall.
//  2. rs2=0, fw_rd[0]=0, wen[0]=1, data=0xFF -> rs2_o=0; rs1=7 no match -> rs1_o=rs1_rf_i.
//  3. rs1=3 matches src0, ready[0]=0 for 1 cycle -> stall_if=stall_id=bubble_ex=1 that cycle only, then forward.
//  4. FLUSH_CYC=2, jump_i pulse -> flush_id=bubble_ex=1 for exactly 3 cycles, second jump_i during FLUSH ignored.
//  5. mc_busy_i high 4 cycles with jump_i=1 throughout -> 4 stall cycles, no flush; jump after busy drops -> flush.
//  6. rst asserted in FLUSH cycle 1 -> next edge state RUN; with HAZARD_PERF_EN all perf counters read 0.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared definitions for the pipeline hazard/forwarding controller.
//  - hz_state_e : controller state encoding (RUN / MC / FLUSH)
//  - NOP_INSN   : canonical RV NOP (addi x0,x0,0) loaded by pipeline bubbles
//  - RIDX_W_DEF : default register index width
package hazard_pkg;

  typedef enum logic [1:0] {
    HZ_RUN   = 2'd0,
    HZ_MC    = 2'd1,
    HZ_FLUSH = 2'd2
  } hz_state_e;

  localparam logic [31:0] NOP_INSN   = 32'h0000_0013;
  localparam int          RIDX_W_DEF = 5;

endpackage

// File: rtl/pipe_hazard_unit_if.sv
// Bus between the pipeline datapath and the hazard unit.
//  master : pipeline side (drives ID operands, forwarding sources, EX status;
//           receives resolved operands and stall/flush controls)
//  slave  : hazard unit side
// Forwarding buses are packed, source k at [k*W +: W]; source 0 is youngest.
interface pipe_hazard_unit_if #(
  parameter int XLEN   = 64,
  parameter int RIDX_W = hazard_pkg::RIDX_W_DEF,
  parameter int N_FWD  = 3
);
  logic [RIDX_W-1:0]       rs1_idx_i;
  logic [RIDX_W-1:0]       rs2_idx_i;
  logic [XLEN-1:0]         rs1_rf_i;
  logic [XLEN-1:0]         rs2_rf_i;
  logic [N_FWD*RIDX_W-1:0] fw_rd_i;
  logic [N_FWD-1:0]        fw_wen_i;
  logic [N_FWD-1:0]        fw_ready_i;
  logic [N_FWD*XLEN-1:0]   fw_data_i;
  logic                    mc_busy_i;
  logic                    jump_i;
  logic [XLEN-1:0]         rs1_o;
  logic [XLEN-1:0]         rs2_o;
  logic                    stall_if_o;
  logic                    stall_id_o;
  logic                    bubble_ex_o;
  logic                    bubble_ls_o;
  logic                    flush_id_o;

  modport master (
    output rs1_idx_i, rs2_idx_i, rs1_rf_i, rs2_rf_i,
           fw_rd_i, fw_wen_i, fw_ready_i, fw_data_i, mc_busy_i, jump_i,
    input  rs1_o, rs2_o, stall_if_o, stall_id_o, bubble_ex_o, bubble_ls_o, flush_id_o
  );

  modport slave (
    input  rs1_idx_i, rs2_idx_i, rs1_rf_i, rs2_rf_i,
           fw_rd_i, fw_wen_i, fw_ready_i, fw_data_i, mc_busy_i, jump_i,
    output rs1_o, rs2_o, stall_if_o, stall_id_o, bubble_ex_o, bubble_ls_o, flush_id_o
  );
endinterface

// File: rtl/pipe_hazard_unit_fwd_sel.sv
// fwd_sel: priority forwarding match + mux for one source operand.
//  idx      in  register index read by the ID instruction
//  rf_data  in  register file read data for idx
//  fw_rd    in  packed rd of each forwarding source
//  fw_wen   in  source k writes rd
//  fw_ready in  source k result valid this cycle
//  fw_data  in  packed result of each source
//  data     out resolved operand (x0 -> zero, youngest matching source wins)
//  hazard   out winning source has no data yet (load-use)
module fwd_sel #(
  parameter int XLEN   = 64,
  parameter int RIDX_W = 5,
  parameter int N_FWD  = 3
) (
  input  logic [RIDX_W-1:0]       idx,
  input  logic [XLEN-1:0]         rf_data,
  input  logic [N_FWD*RIDX_W-1:0] fw_rd,
  input  logic [N_FWD-1:0]        fw_wen,
  input  logic [N_FWD-1:0]        fw_ready,
  input  logic [N_FWD*XLEN-1:0]   fw_data,
  output logic [XLEN-1:0]         data,
  output logic                    hazard
);
  logic [N_FWD-1:0] hit;

  for (genvar gi = 0; gi < N_FWD; gi++) begin : g_hit
    assign hit[gi] = fw_wen[gi] && (fw_rd[gi*RIDX_W +: RIDX_W] == idx);
  end

  // Walk from oldest to youngest so the youngest match overwrites the rest.
  // x0 is never forwarded; it reads as zero regardless of the regfile.
  always_comb begin
    data   = rf_data;
    hazard = 1'b0;
    if (idx == '0) begin
      data = '0;
    end else begin
      for (int k = N_FWD - 1; k >= 0; k--) begin
        if (hit[k]) begin
          data   = fw_data[k*XLEN +: XLEN];
          hazard = !fw_ready[k];
        end
      end
    end
  end
endmodule

// File: rtl/pipe_hazard_unit.sv
// pipe_hazard_unit: hazard/forwarding controller for the IF/ID/EX/LS/WB pipeline.
//  clk, rst : clock, synchronous active-high reset
//  hz       : pipe_hazard_unit_if.slave (operands, forwarding sources, EX status,
//             resolved operands, stall/bubble/flush controls)
//  HAZARD_PERF_EN (optional macro): adds perf_lu_cnt_o, perf_mc_cnt_o,
//             perf_flush_cnt_o, 32-bit saturating event counters.
// Priority within a cycle: mc_busy > jump > load-use. Controls respond in the
// same cycle as their cause; the state register only tracks MC / FLUSH episodes.
module pipe_hazard_unit
  import hazard_pkg::*;
#(
  parameter int XLEN      = 64,
  parameter int RIDX_W    = RIDX_W_DEF,
  parameter int N_FWD     = 3,
  parameter int FLUSH_CYC = 1
) (
  input  logic clk,
  input  logic rst,
  pipe_hazard_unit_if.slave hz
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0] perf_lu_cnt_o,
  output logic [31:0] perf_mc_cnt_o,
  output logic [31:0] perf_flush_cnt_o
`endif
);
  localparam int CNT_W = (FLUSH_CYC < 1) ? 1 : $clog2(FLUSH_CYC + 1);

  hz_state_e        state_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             lu1, lu2, lu;
  logic             mc_stall, redirect, lu_stall, in_flush;

  fwd_sel #(.XLEN(XLEN), .RIDX_W(RIDX_W), .N_FWD(N_FWD)) u_fwd_rs1 (
    .idx(hz.rs1_idx_i), .rf_data(hz.rs1_rf_i), .fw_rd(hz.fw_rd_i), .fw_wen(hz.fw_wen_i),
    .fw_ready(hz.fw_ready_i), .fw_data(hz.fw_data_i), .data(hz.rs1_o), .hazard(lu1)
  );

  fwd_sel #(.XLEN(XLEN), .RIDX_W(RIDX_W), .N_FWD(N_FWD)) u_fwd_rs2 (
    .idx(hz.rs2_idx_i), .rf_data(hz.rs2_rf_i), .fw_rd(hz.fw_rd_i), .fw_wen(hz.fw_wen_i),
    .fw_ready(hz.fw_ready_i), .fw_data(hz.fw_data_i), .data(hz.rs2_o), .hazard(lu2)
  );

  assign lu       = lu1 | lu2;
  assign in_flush = !rst && (state_reg == HZ_FLUSH);
  // A redirect arriving while EX is busy is dropped: EX holds the branch and
  // presents it again after busy clears. The cycle busy drops also ignores it.
  assign mc_stall = !rst && ((state_reg == HZ_RUN) || (state_reg == HZ_MC)) && hz.mc_busy_i;
  assign redirect = !rst && (state_reg == HZ_RUN) && !hz.mc_busy_i && hz.jump_i;
  // Load-use is not raised during FLUSH because its consumer is being squashed.
  assign lu_stall = !rst && lu && !hz.mc_busy_i &&
                    (((state_reg == HZ_RUN) && !hz.jump_i) || (state_reg == HZ_MC));

  assign hz.stall_if_o  = mc_stall | lu_stall;
  assign hz.stall_id_o  = mc_stall | lu_stall;
  assign hz.bubble_ex_o = rst | redirect | in_flush | lu_stall;
  assign hz.bubble_ls_o = rst | mc_stall;
  assign hz.flush_id_o  = rst | redirect | in_flush;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= HZ_RUN;
      cnt_reg   <= '0;
    end else begin
      case (state_reg)
        HZ_RUN: begin
          if (hz.mc_busy_i) begin
            state_reg <= HZ_MC;
          end else if (hz.jump_i) begin
            state_reg <= HZ_FLUSH;
            cnt_reg   <= CNT_W'(FLUSH_CYC - 1);
          end
        end
        HZ_MC: begin
          if (!hz.mc_busy_i) state_reg <= HZ_RUN;
        end
        HZ_FLUSH: begin
          if (cnt_reg == '0) state_reg <= HZ_RUN;
          else               cnt_reg   <= cnt_reg - 1'b1;
        end
        default: state_reg <= HZ_RUN;
      endcase
    end
  end

`ifdef HAZARD_PERF_EN
  logic [31:0] perf_lu_reg, perf_mc_reg, perf_flush_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_lu_reg    <= '0;
      perf_mc_reg    <= '0;
      perf_flush_reg <= '0;
    end else begin
      if (lu_stall && (perf_lu_reg != '1))    perf_lu_reg    <= perf_lu_reg + 1'b1;
      if (mc_stall && (perf_mc_reg != '1))    perf_mc_reg    <= perf_mc_reg + 1'b1;
      if (redirect && (perf_flush_reg != '1)) perf_flush_reg <= perf_flush_reg + 1'b1;
    end
  end

  assign perf_lu_cnt_o    = perf_lu_reg;
  assign perf_mc_cnt_o    = perf_mc_reg;
  assign perf_flush_cnt_o = perf_flush_reg;
`endif
endmodule
